// File: rtl/axil_cfg_master.sv
// AXI4-Lite initiator: converts a command/response stream into single register
// writes/reads, one outstanding transaction, with a per-transaction timeout.
module axil_cfg_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic [CNT_WIDTH-1:0]    txn_count,
  output logic [CNT_WIDTH-1:0]    err_count
);

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RESP} state_t;

  state_t                  state, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [31:0]             tcnt, tcnt_d;
  logic                    awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
  logic                    cmd_ready_d, rsp_valid_d, rsp_timeout_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_d;
  logic [1:0]              rsp_resp_d;
  logic [CNT_WIDTH-1:0]    txn_d, err_d;
  logic                    done;
  logic                    expire;

  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = wstrb_q;

  assign expire = (TIMEOUT_CYCLES != 0) && (tcnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      tcnt          <= '0;
      cmd_ready     <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= '0;
      rsp_timeout   <= 1'b0;
      txn_count     <= '0;
      err_count     <= '0;
    end else begin
      state         <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      tcnt          <= tcnt_d;
      cmd_ready     <= cmd_ready_d;
      m_axi_awvalid <= awvalid_d;
      m_axi_wvalid  <= wvalid_d;
      m_axi_bready  <= bready_d;
      m_axi_arvalid <= arvalid_d;
      m_axi_rready  <= rready_d;
      rsp_valid     <= rsp_valid_d;
      rsp_rdata     <= rsp_rdata_d;
      rsp_resp      <= rsp_resp_d;
      rsp_timeout   <= rsp_timeout_d;
      txn_count     <= txn_d;
      err_count     <= err_d;
    end
  end

  always_comb begin
    state_d       = state;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    tcnt_d        = tcnt;
    awvalid_d     = m_axi_awvalid;
    wvalid_d      = m_axi_wvalid;
    bready_d      = m_axi_bready;
    arvalid_d     = m_axi_arvalid;
    rready_d      = m_axi_rready;
    rsp_valid_d   = rsp_valid;
    rsp_rdata_d   = rsp_rdata;
    rsp_resp_d    = rsp_resp;
    rsp_timeout_d = rsp_timeout;
    txn_d         = txn_count;
    err_d         = err_count;
    done          = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          tcnt_d  = '0;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WADDR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RADDR;
          end
        end
      end
      WADDR: begin
        // AW and W retire independently; a low valid here means that channel is done
        if (m_axi_awvalid && m_axi_awready) awvalid_d = 1'b0;
        if (m_axi_wvalid && m_axi_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WRESP;
          done     = 1'b1;
        end
      end
      WRESP: begin
        if (m_axi_bvalid && m_axi_bready) begin
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_resp_d    = m_axi_bresp;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
          done          = 1'b1;
        end
      end
      RADDR: begin
        if (m_axi_arvalid && m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RDATA;
          done      = 1'b1;
        end
      end
      RDATA: begin
        if (m_axi_rvalid && m_axi_rready) begin
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_resp_d    = m_axi_rresp;
          rsp_rdata_d   = m_axi_rdata;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
          done          = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          txn_d       = txn_count + 1'b1;
          if (rsp_resp != 2'b00 || rsp_timeout) err_d = err_count + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A handshake landing in the expiry cycle takes precedence over the timeout
    if (state inside {WADDR, WRESP, RADDR, RDATA}) begin
      tcnt_d = tcnt + 1'b1;
      if (expire && !done) begin
        awvalid_d     = 1'b0;
        wvalid_d      = 1'b0;
        bready_d      = 1'b0;
        arvalid_d     = 1'b0;
        rready_d      = 1'b0;
        rsp_valid_d   = 1'b1;
        rsp_resp_d    = 2'b10;
        rsp_rdata_d   = '0;
        rsp_timeout_d = 1'b1;
        state_d       = RESP;
      end
    end

    cmd_ready_d = (state_d == IDLE);
  end

endmodule
